// File: rtl/tft_call_sched_pkg.sv
// ---------------------------------------------------------------------------
// tft_call_sched_pkg
// Shared definitions for the TFT call scheduler: the one-hot call encodings
// understood by the TFT base module, the scheduler state type and a helper
// that reduces a (possibly multi-hot) call vector to a single legal call.
// ---------------------------------------------------------------------------
package tft_call_sched_pkg;

    localparam logic [2:0] CALL_NONE  = 3'b000;
    localparam logic [2:0] CALL_INIT  = 3'b001;
    localparam logic [2:0] CALL_CLEAR = 3'b010;
    localparam logic [2:0] CALL_WRITE = 3'b100;

    typedef enum logic [2:0] {
        ST_INIT_ISSUE,
        ST_INIT_WAIT,
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_GAP
    } schedState_t;

    // A requester may present more than one call bit; the lowest one wins so
    // the base module only ever sees a one-hot call.
    function automatic logic [2:0] lowestCall(input logic [2:0] callIn);
        if (callIn[0]) begin
            return CALL_INIT;
        end else if (callIn[1]) begin
            return CALL_CLEAR;
        end else if (callIn[2]) begin
            return CALL_WRITE;
        end else begin
            return CALL_NONE;
        end
    endfunction

endpackage

// File: rtl/tft_call_sched_rr_pick.sv
// ---------------------------------------------------------------------------
// tft_call_sched_rr_pick
// Combinational round-robin pick: finds the first requester with req set,
// searching upward from the pointer and wrapping around.
// Ports:
//   req_i    NREQ  request vector, one bit per requester
//   ptr_i    PW    index where the search starts
//   grant_o  NREQ  one-hot winner (all zero when nobody requests)
//   index_o  PW    binary index of the winner
//   valid_o  1     a winner was found
// ---------------------------------------------------------------------------
module tft_call_sched_rr_pick
    import tft_call_sched_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [PW-1:0]   index_o,
    output logic            valid_o
);

    logic [PW:0]   sum;
    logic [PW-1:0] idx;

    // Walk the NREQ candidate positions in priority order starting at the
    // pointer; the extra sum bit lets the wrap be a single subtraction.
    always_comb begin
        grant_o = '0;
        index_o = '0;
        valid_o = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int i = 0; i < NREQ; i++) begin
            sum = {1'b0, ptr_i} + (PW+1)'(i);
            if (sum >= (PW+1)'(NREQ)) begin
                sum = sum - (PW+1)'(NREQ);
            end
            idx = sum[PW-1:0];
            if (!valid_o && req_i[idx]) begin
                valid_o      = 1'b1;
                grant_o[idx] = 1'b1;
                index_o      = idx;
            end
        end
    end

endmodule

// File: rtl/tft_call_sched.sv
// ---------------------------------------------------------------------------
// tft_call_sched
// Scheduler in front of the TFT base module. After reset it optionally runs
// the panel INIT call, then shares the base module among NREQ requesters
// with round-robin arbitration, one call in flight at a time. A watchdog
// aborts calls whose completion never arrives.
// Ports:
//   clk_i       1        system clock
//   rst_i       1        asynchronous reset, active high
//   call_i      3*NREQ   per-requester one-hot call {WRITE,CLEAR,INIT}
//   data_i      32*NREQ  per-requester call argument
//   done_o      NREQ     one-cycle completion pulse per requester
//   grant_o     NREQ     one-hot owner of the base module
//   busy_o      1        a call (including init) is in flight
//   initDone_o  1        init call has completed (or is disabled)
//   timeout_o   1        one-cycle pulse when the watchdog aborts a call
//   tftCall_o   3        registered call to the base module
//   tftData_o   32       registered argument to the base module
//   tftDone_i   1        completion pulse from the base module
// ---------------------------------------------------------------------------
module tft_call_sched
    import tft_call_sched_pkg::*;
#(
    parameter int NREQ      = 3,
    parameter int AUTO_INIT = 1,
    parameter int TIMEOUT   = 1048576
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [3*NREQ-1:0]  call_i,
    input  logic [32*NREQ-1:0] data_i,
    output logic [NREQ-1:0]    done_o,
    output logic [NREQ-1:0]    grant_o,
    output logic               busy_o,
    output logic               initDone_o,
    output logic               timeout_o,
    output logic [2:0]         tftCall_o,
    output logic [31:0]        tftData_o,
    input  logic               tftDone_i
);

    localparam int PW  = $clog2(NREQ);
    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

    schedState_t     state_q;
    logic [PW-1:0]   rrPtr_q;
    logic [PW-1:0]   owner_q;
    logic [NREQ-1:0] ownerOh_q;
    logic [WDW-1:0]  wdog_q;
    logic [2:0]      tftCall_q;
    logic [31:0]     tftData_q;
    logic [NREQ-1:0] grant_q;
    logic [NREQ-1:0] done_q;
    logic            busy_q;
    logic            initDone_q;
    logic            timeout_q;

    logic [2:0]      callSlice [NREQ];
    logic [31:0]     dataSlice [NREQ];
    logic [NREQ-1:0] reqVec;
    logic [NREQ-1:0] pickGrant;
    logic [PW-1:0]   pickIdx;
    logic            pickValid;

    // Split the flat requester buses into per-requester views.
    always_comb begin
        reqVec = '0;
        for (int k = 0; k < NREQ; k++) begin
            callSlice[k] = call_i[3*k +: 3];
            dataSlice[k] = data_i[32*k +: 32];
            reqVec[k]    = |call_i[3*k +: 3];
        end
    end

    tft_call_sched_rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req_i   (reqVec),
        .ptr_i   (rrPtr_q),
        .grant_o (pickGrant),
        .index_o (pickIdx),
        .valid_o (pickValid)
    );

    // Scheduler FSM with all outputs registered. done/timeout are pulses, so
    // they default low every cycle and are raised only on the exit edge.
    // The owner is chosen in IDLE, but its call and data are captured one
    // cycle later in ISSUE; the requester holds them until its done pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= (AUTO_INIT != 0) ? ST_INIT_ISSUE : ST_IDLE;
            rrPtr_q    <= '0;
            owner_q    <= '0;
            ownerOh_q  <= '0;
            wdog_q     <= '0;
            tftCall_q  <= CALL_NONE;
            tftData_q  <= '0;
            grant_q    <= '0;
            done_q     <= '0;
            busy_q     <= 1'b0;
            initDone_q <= (AUTO_INIT == 0);
            timeout_q  <= 1'b0;
        end else begin
            done_q    <= '0;
            timeout_q <= 1'b0;
            case (state_q)
                ST_INIT_ISSUE: begin
                    tftCall_q <= CALL_INIT;
                    tftData_q <= '0;
                    busy_q    <= 1'b1;
                    wdog_q    <= '0;
                    state_q   <= ST_INIT_WAIT;
                end
                ST_INIT_WAIT: begin
                    if (tftDone_i) begin
                        tftCall_q  <= CALL_NONE;
                        initDone_q <= 1'b1;
                        state_q    <= ST_GAP;
                    end else if (wdog_q == WD_LAST) begin
                        // initDone stays low, so GAP loops back for a retry.
                        tftCall_q <= CALL_NONE;
                        timeout_q <= 1'b1;
                        state_q   <= ST_GAP;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (initDone_q && pickValid) begin
                        owner_q   <= pickIdx;
                        ownerOh_q <= pickGrant;
                        state_q   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    tftCall_q <= lowestCall(callSlice[owner_q]);
                    tftData_q <= dataSlice[owner_q];
                    grant_q   <= ownerOh_q;
                    busy_q    <= 1'b1;
                    wdog_q    <= '0;
                    state_q   <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A completion arriving on the expiry cycle wins, so no
                    // timeout is flagged; the requester gets done either way.
                    if (tftDone_i || (wdog_q == WD_LAST)) begin
                        tftCall_q <= CALL_NONE;
                        done_q    <= grant_q;
                        grant_q   <= '0;
                        timeout_q <= !tftDone_i;
                        rrPtr_q   <= (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
                        state_q   <= ST_GAP;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                end
                ST_GAP: begin
                    busy_q  <= 1'b0;
                    state_q <= initDone_q ? ST_IDLE : ST_INIT_ISSUE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign done_o     = done_q;
    assign grant_o    = grant_q;
    assign busy_o     = busy_q;
    assign initDone_o = initDone_q;
    assign timeout_o  = timeout_q;
    assign tftCall_o  = tftCall_q;
    assign tftData_o  = tftData_q;

endmodule

// File: tb/tb_tft_call_sched.sv
// ---------------------------------------------------------------------------
// tb_tft_call_sched
// Directed bench for the TFT call scheduler. A transaction-level model
// predicts every output each cycle; hand-computed literals pin latencies,
// arbitration order and the watchdog.
// ---------------------------------------------------------------------------
module tb_tft_call_sched;

    localparam int NREQ    = 3;
    localparam int TIMEOUT = 16;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [3*NREQ-1:0]  callVec = '0;
    logic [32*NREQ-1:0] dataVec = '0;
    logic               tftDone = 1'b0;
    logic [NREQ-1:0]    dutDone;
    logic [NREQ-1:0]    dutGrant;
    logic               dutBusy;
    logic               dutInitDone;
    logic               dutTimeout;
    logic [2:0]         dutCall;
    logic [31:0]        dutData;

    int checks = 0;
    int errors = 0;
    int doneDelay = 5;
    bit autoDrop = 1'b1;

    // Model predictions for the cycle following each rising edge.
    logic [2:0]      expCall = '0;
    logic [31:0]     expData = '0;
    logic [NREQ-1:0] expGrant = '0;
    logic [NREQ-1:0] expDone = '0;
    logic            expBusy = 1'b0;
    logic            expInitDone = 1'b0;
    logic            expTimeout = 1'b0;
    int              mPtr = 0;
    bit              aborted = 1'b0;

    always #5 clk = ~clk;

    tft_call_sched #(
        .NREQ      (NREQ),
        .AUTO_INIT (1),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .call_i     (callVec),
        .data_i     (dataVec),
        .done_o     (dutDone),
        .grant_o    (dutGrant),
        .busy_o     (dutBusy),
        .initDone_o (dutInitDone),
        .timeout_o  (dutTimeout),
        .tftCall_o  (dutCall),
        .tftData_o  (dutData),
        .tftDone_i  (tftDone)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int k, input logic [2:0] c, input logic [31:0] d);
        callVec[3*k +: 3]   = c;
        dataVec[32*k +: 32] = d;
    endtask

    // Requesters release their call as soon as they see their done pulse.
    task automatic nextCycle();
        @(posedge clk);
        #1;
        if (autoDrop) begin
            for (int k = 0; k < NREQ; k++) begin
                if (dutDone[k]) callVec[3*k +: 3] = 3'b000;
            end
        end
    endtask

    function automatic int oh2idx(input logic [NREQ-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < NREQ; i++) begin
            if (v == (NREQ'(1) << i)) r = i;
        end
        return r;
    endfunction

    // Base-module stand-in: completes a call in its doneDelay-th visible
    // cycle; doneDelay = 0 means it never answers.
    initial begin
        int age;
        age = 0;
        forever begin
            @(posedge clk);
            #1;
            if (dutCall != 3'b000 && !rst) age++;
            else age = 0;
            tftDone = (doneDelay > 0) && (age == doneDelay);
        end
    end

    // ---------------- transaction-level model ----------------
    task automatic tick();
        @(posedge clk or posedge rst);
        if (rst) aborted = 1'b1;
    endtask

    task automatic modelReset();
        expCall = '0; expData = '0; expGrant = '0; expDone = '0;
        expBusy = 1'b0; expInitDone = 1'b0; expTimeout = 1'b0; mPtr = 0;
    endtask

    // A call stays outstanding until the base module answers or it has been
    // visible for TIMEOUT cycles, whichever comes first (answer wins ties).
    task automatic modelAwaitCompletion(output bit timedOut);
        int waited;
        waited = 0;
        timedOut = 1'b0;
        forever begin
            tick();
            if (aborted) return;
            waited++;
            if (tftDone) return;
            if (waited == TIMEOUT) begin
                timedOut = 1'b1;
                return;
            end
        end
    endtask

    task automatic modelRun();
        bit timedOut;
        int k;
        logic [2:0] c;
        aborted = 1'b0;
        modelReset();
        while (!expInitDone) begin
            tick(); if (aborted) return;
            expCall = 3'b001; expData = '0; expBusy = 1'b1;
            modelAwaitCompletion(timedOut); if (aborted) return;
            expCall = '0;
            if (timedOut) expTimeout = 1'b1;
            else expInitDone = 1'b1;
            tick(); if (aborted) return;
            expTimeout = 1'b0; expBusy = 1'b0;
        end
        forever begin
            tick(); if (aborted) return;
            k = -1;
            for (int i = 0; i < NREQ; i++) begin
                if (k < 0 && callVec[3*((mPtr+i)%NREQ) +: 3] != 3'b000) k = (mPtr + i) % NREQ;
            end
            if (k < 0) continue;
            tick(); if (aborted) return;
            c = callVec[3*k +: 3];
            expCall  = c[0] ? 3'b001 : c[1] ? 3'b010 : c[2] ? 3'b100 : 3'b000;
            expData  = dataVec[32*k +: 32];
            expGrant = NREQ'(1 << k);
            expBusy  = 1'b1;
            modelAwaitCompletion(timedOut); if (aborted) return;
            expCall = '0; expGrant = '0; expDone = NREQ'(1 << k);
            expTimeout = timedOut; mPtr = (k + 1) % NREQ;
            tick(); if (aborted) return;
            expDone = '0; expTimeout = 1'b0; expBusy = 1'b0;
        end
    endtask

    initial begin
        forever begin
            wait (rst == 1'b0);
            modelRun();
        end
    end

    // Compare every cycle on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                checkOutput("rstCall", dutCall, 0);
                checkOutput("rstGrant", dutGrant, 0);
                checkOutput("rstBusy", dutBusy, 0);
                checkOutput("rstInitDone", dutInitDone, 0);
            end else begin
                checkOutput("tftCall", dutCall, expCall);
                checkOutput("tftData", dutData, expData);
                checkOutput("grant", dutGrant, expGrant);
                checkOutput("done", dutDone, expDone);
                checkOutput("busy", dutBusy, expBusy);
                checkOutput("initDone", dutInitDone, expInitDone);
                checkOutput("timeout", dutTimeout, expTimeout);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL globalTimeout actual=running required=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int n;
        int vis;
        int grantsSeen;
        logic [NREQ-1:0] prevGrant;
        int order [6];
        int expOrder [6] = '{0, 1, 2, 0, 1, 2};

        repeat (3) @(posedge clk);
        #1;
        checkOutput("resetInitDone", dutInitDone, 0);
        checkOutput("resetBusy", dutBusy, 0);
        rst = 1'b0;

        // Init call answered in its 5th cycle.
        n = 0;
        while (dutInitDone !== 1'b1 && n < 50) begin nextCycle(); n++; end
        checkOutput("initLatency", n, 6);
        checkOutput("initGapBusy", dutBusy, 1);
        checkOutput("initNoDone", dutDone, 0);
        nextCycle();
        checkOutput("initBusyLow", dutBusy, 0);
        repeat (2) nextCycle();

        // All requesters hold CLEAR: strict rotation.
        autoDrop = 1'b0;
        doneDelay = 2;
        for (int k = 0; k < NREQ; k++) applyStimulus(k, 3'b010, 32'hC1EA_0000 + k);
        grantsSeen = 0; prevGrant = '0; n = 0;
        while (n < 400 && !(grantsSeen >= 6 && dutDone != 0)) begin
            nextCycle(); n++;
            if (dutGrant != 0 && prevGrant == 0 && grantsSeen < 6) begin
                order[grantsSeen] = oh2idx(dutGrant);
                grantsSeen++;
            end
            prevGrant = dutGrant;
        end
        checkOutput("rrBudget", (n < 400), 1);
        for (int i = 0; i < 6; i++) checkOutput($sformatf("rrOrder%0d", i), order[i], expOrder[i]);
        for (int k = 0; k < NREQ; k++) applyStimulus(k, 3'b000, 32'h0);
        autoDrop = 1'b1;
        repeat (3) nextCycle();

        // Single WRITE from requester 1.
        doneDelay = 5;
        applyStimulus(1, 3'b100, 32'h0012_F800);
        n = 0;
        while (dutCall == 3'b000 && n < 20) begin nextCycle(); n++; end
        checkOutput("writeLatency", n, 2);
        checkOutput("writeCall", dutCall, 3'b100);
        checkOutput("writeData", dutData, 32'h0012_F800);
        checkOutput("writeGrant", dutGrant, 3'b010);
        while (dutDone == 0 && n < 50) begin nextCycle(); n++; end
        checkOutput("writeDoneLatency", n, 7);
        checkOutput("writeDone", dutDone, 3'b010);
        checkOutput("writeGrantDrop", dutGrant, 0);
        nextCycle();
        checkOutput("writeDonePulse", dutDone, 0);
        repeat (3) nextCycle();

        // Requester 2 hangs; requester 0 waits behind it.
        doneDelay = 0;
        applyStimulus(2, 3'b100, 32'hDEAD_0002);
        applyStimulus(0, 3'b010, 32'h0000_0BAD);
        n = 0;
        while (dutCall == 3'b000 && n < 20) begin nextCycle(); n++; end
        checkOutput("hangGrant", dutGrant, 3'b100);
        vis = 0;
        while (dutCall != 3'b000 && vis < 40) begin vis++; nextCycle(); end
        checkOutput("hangCycles", vis, TIMEOUT);
        checkOutput("hangTimeout", dutTimeout, 1);
        checkOutput("hangDone", dutDone, 3'b100);
        doneDelay = 3;
        n = 0;
        while (dutGrant == 0 && n < 20) begin nextCycle(); n++; end
        checkOutput("nextGrant", dutGrant, 3'b001);
        checkOutput("nextCall", dutCall, 3'b010);
        checkOutput("nextData", dutData, 32'h0000_0BAD);
        while (dutDone == 0 && n < 50) begin nextCycle(); n++; end
        checkOutput("nextDone", dutDone, 3'b001);
        checkOutput("nextNoTimeout", dutTimeout, 0);
        repeat (3) nextCycle();

        // Multi-hot call, answer lands on the expiry cycle.
        doneDelay = TIMEOUT;
        applyStimulus(0, 3'b110, 32'h5A5A_A5A5);
        n = 0;
        while (dutCall == 3'b000 && n < 20) begin nextCycle(); n++; end
        checkOutput("maskCall", dutCall, 3'b010);
        vis = 0;
        while (dutCall != 3'b000 && vis < 40) begin vis++; nextCycle(); end
        checkOutput("tieCycles", vis, TIMEOUT);
        checkOutput("tieDone", dutDone, 3'b001);
        checkOutput("tieNoTimeout", dutTimeout, 0);
        repeat (3) nextCycle();

        // Reset in the middle of a call.
        doneDelay = 0;
        applyStimulus(1, 3'b100, 32'h1111_2222);
        n = 0;
        while (dutCall == 3'b000 && n < 20) begin nextCycle(); n++; end
        repeat (3) nextCycle();
        #2 rst = 1'b1;
        #1;
        checkOutput("midRstCall", dutCall, 0);
        checkOutput("midRstGrant", dutGrant, 0);
        checkOutput("midRstInitDone", dutInitDone, 0);
        for (int k = 0; k < NREQ; k++) applyStimulus(k, 3'b000, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        doneDelay = 5;
        nextCycle();
        checkOutput("rerunInitCall", dutCall, 3'b001);
        n = 1;
        while (dutInitDone !== 1'b1 && n < 50) begin nextCycle(); n++; end
        checkOutput("rerunInitLatency", n, 6);
        repeat (3) nextCycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
